// File: rtl/sdcard_cmd_seq.sv
// SPI-mode SD command sequencer: drives the byte engine's register port
// through one command frame, its response and an optional data block.
module sdcard_cmd_seq #(
    parameter int NCR_MAX   = 8,
    parameter int TOKEN_MAX = 4095,
    parameter int BLOCK_LEN = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  clk_div,
    input  logic        cmd_start,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic [2:0]  rsp_extra,
    input  logic        data_rd,
    output logic        busy,
    output logic        done,
    output logic [7:0]  r1,
    output logic [31:0] rsp_ext,
    output logic        err_timeout,
    output logic        err_token,
    output logic        err_crc,
    output logic        dat_valid,
    output logic [7:0]  dat_byte,
    output logic [3:0]  m_adr,
    output logic        m_cs,
    output logic        m_we,
    output logic [3:0]  m_sel,
    output logic [31:0] m_d,
    input  logic [31:0] m_q
);

    // Register-map bit 0 is the MSB, so map bit k lands on [31-k] here.
    localparam logic [11:0] NCR_LAST = 12'(NCR_MAX - 1);
    localparam logic [11:0] TOK_LAST = 12'(TOKEN_MAX - 1);
    localparam logic [11:0] BLK_LAST = 12'(BLOCK_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_POLL, S_CRC7, S_PRESET, S_CRC16, S_DESEL, S_DONE
    } state_t;

    typedef enum logic [3:0] {
        P_PRE, P_CMD, P_CRC, P_NCR, P_EXT, P_TOK, P_DATA, P_DCRC, P_TAIL
    } step_t;

    state_t      state_q, state_n;
    step_t       step_q, step_n;
    logic [11:0] cnt_q, cnt_n;
    logic [5:0]  idx_q, idx_n;
    logic [31:0] arg_q, arg_n;
    logic [2:0]  ext_q, ext_n;
    logic        rd_q, rd_n;
    logic [7:0]  div_q, div_n;
    logic [7:0]  crc7_q, crc7_n;
    logic [7:0]  r1_q, r1_n;
    logic [31:0] rsp_q, rsp_n;
    logic        to_q, to_n;
    logic        tok_q, tok_n;
    logic        crc_q, crc_n;
    logic        dv_q, dv_n;
    logic [7:0]  db_q, db_n;
    logic [7:0]  tx_byte;
    logic [7:0]  rx;
    logic        eng_busy;
    logic        unused_q;

    assign rx       = m_q[7:0];
    assign eng_busy = m_q[8];
    assign unused_q = ^m_q[23:16];

    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done        = (state_q == S_DONE);
    assign r1          = r1_q;
    assign rsp_ext     = rsp_q;
    assign err_timeout = to_q;
    assign err_token   = tok_q;
    assign err_crc     = crc_q;
    assign dat_valid   = dv_q;
    assign dat_byte    = db_q;

    // Byte sent by the current step: command bytes, the CRC7 or idle FF.
    always_comb begin
        tx_byte = 8'hFF;
        if (step_q == P_CMD) begin
            case (cnt_q[2:0])
                3'd0:    tx_byte = {2'b01, idx_q};
                3'd1:    tx_byte = arg_q[31:24];
                3'd2:    tx_byte = arg_q[23:16];
                3'd3:    tx_byte = arg_q[15:8];
                3'd4:    tx_byte = arg_q[7:0];
                default: tx_byte = 8'hFF;
            endcase
        end else if (step_q == P_CRC) begin
            tx_byte = crc7_q;
        end
    end

    // Sequencer next-state, bus cycle generation and datapath updates.
    always_comb begin
        state_n = state_q;
        step_n  = step_q;
        cnt_n   = cnt_q;
        idx_n   = idx_q;
        arg_n   = arg_q;
        ext_n   = ext_q;
        rd_n    = rd_q;
        div_n   = div_q;
        crc7_n  = crc7_q;
        r1_n    = r1_q;
        rsp_n   = rsp_q;
        to_n    = to_q;
        tok_n   = tok_q;
        crc_n   = crc_q;
        dv_n    = 1'b0;
        db_n    = db_q;
        m_cs    = 1'b0;
        m_we    = 1'b0;
        m_adr   = 4'd0;
        m_sel   = 4'b0000;
        m_d     = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    idx_n   = cmd_index;
                    arg_n   = cmd_arg;
                    ext_n   = rsp_extra;
                    rd_n    = data_rd;
                    div_n   = clk_div;
                    r1_n    = 8'hFF;
                    rsp_n   = 32'd0;
                    to_n    = 1'b0;
                    tok_n   = 1'b0;
                    crc_n   = 1'b0;
                    step_n  = P_PRE;
                    cnt_n   = 12'd0;
                    state_n = S_WR;
                end
            end
            S_WR: begin
                m_cs        = 1'b1;
                m_we        = 1'b1;
                m_sel       = 4'b1011;
                m_d[31:24]  = div_q;
                m_d[12]     = (step_q != P_PRE);
                m_d[8]      = 1'b1;
                m_d[7:0]    = tx_byte;
                state_n     = S_POLL;
            end
            S_POLL: begin
                m_cs = 1'b1;
                if (!eng_busy) begin
                    state_n = S_WR;
                    case (step_q)
                        P_PRE: begin
                            step_n = P_CMD;
                            cnt_n  = 12'd0;
                        end
                        P_CMD: begin
                            if (cnt_q == 12'd4) begin
                                step_n  = P_CRC;
                                state_n = S_CRC7;
                            end else begin
                                cnt_n = cnt_q + 12'd1;
                            end
                        end
                        P_CRC: begin
                            step_n = P_NCR;
                            cnt_n  = 12'd0;
                        end
                        P_NCR: begin
                            if (!rx[7]) begin
                                r1_n  = rx;
                                cnt_n = 12'd0;
                                if (ext_q != 3'd0)
                                    step_n = P_EXT;
                                else if (rd_q && rx == 8'h00)
                                    step_n = P_TOK;
                                else
                                    step_n = P_TAIL;
                            end else if (cnt_q == NCR_LAST) begin
                                to_n   = 1'b1;
                                step_n = P_TAIL;
                            end else begin
                                cnt_n = cnt_q + 12'd1;
                            end
                        end
                        P_EXT: begin
                            rsp_n = {rsp_q[23:0], rx};
                            if (cnt_q + 12'd1 == {9'd0, ext_q}) begin
                                cnt_n = 12'd0;
                                if (rd_q && r1_q == 8'h00)
                                    step_n = P_TOK;
                                else
                                    step_n = P_TAIL;
                            end else begin
                                cnt_n = cnt_q + 12'd1;
                            end
                        end
                        P_TOK: begin
                            if (rx == 8'hFE) begin
                                state_n = S_PRESET;
                            end else if (rx[7:4] == 4'h0) begin
                                tok_n  = 1'b1;
                                step_n = P_TAIL;
                            end else if (cnt_q == TOK_LAST) begin
                                to_n   = 1'b1;
                                step_n = P_TAIL;
                            end else begin
                                cnt_n = cnt_q + 12'd1;
                            end
                        end
                        P_DATA: begin
                            dv_n = 1'b1;
                            db_n = rx;
                            if (cnt_q == BLK_LAST) begin
                                cnt_n  = 12'd0;
                                step_n = P_DCRC;
                            end else begin
                                cnt_n = cnt_q + 12'd1;
                            end
                        end
                        P_DCRC: begin
                            if (cnt_q == 12'd1)
                                state_n = S_CRC16;
                            else
                                cnt_n = cnt_q + 12'd1;
                        end
                        P_TAIL: state_n = S_DESEL;
                        default: step_n = P_TAIL;
                    endcase
                end
            end
            S_CRC7: begin
                m_cs    = 1'b1;
                m_adr   = 4'd1;
                crc7_n  = m_q[31:24];
                step_n  = P_CRC;
                state_n = S_WR;
            end
            S_PRESET: begin
                m_cs    = 1'b1;
                m_we    = 1'b1;
                m_adr   = 4'd1;
                m_sel   = 4'b0011;
                step_n  = P_DATA;
                cnt_n   = 12'd0;
                state_n = S_WR;
            end
            S_CRC16: begin
                m_cs  = 1'b1;
                m_adr = 4'd1;
                if (m_q[15:0] != 16'd0)
                    crc_n = 1'b1;
                step_n  = P_TAIL;
                state_n = S_WR;
            end
            S_DESEL: begin
                m_cs    = 1'b1;
                m_we    = 1'b1;
                m_sel   = 4'b0010;
                state_n = S_DONE;
            end
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any sequence in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            step_q  <= P_PRE;
            cnt_q   <= 12'd0;
            idx_q   <= 6'd0;
            arg_q   <= 32'd0;
            ext_q   <= 3'd0;
            rd_q    <= 1'b0;
            div_q   <= 8'd0;
            crc7_q  <= 8'd0;
            r1_q    <= 8'hFF;
            rsp_q   <= 32'd0;
            to_q    <= 1'b0;
            tok_q   <= 1'b0;
            crc_q   <= 1'b0;
            dv_q    <= 1'b0;
            db_q    <= 8'd0;
        end else begin
            state_q <= state_n;
            step_q  <= step_n;
            cnt_q   <= cnt_n;
            idx_q   <= idx_n;
            arg_q   <= arg_n;
            ext_q   <= ext_n;
            rd_q    <= rd_n;
            div_q   <= div_n;
            crc7_q  <= crc7_n;
            r1_q    <= r1_n;
            rsp_q   <= rsp_n;
            to_q    <= to_n;
            tok_q   <= tok_n;
            crc_q   <= crc_n;
            dv_q    <= dv_n;
            db_q    <= db_n;
        end
    end

endmodule

// File: tb/tb_sdcard_cmd_seq.sv
// Bench for sdcard_cmd_seq: byte engine + card model on the register port,
// transaction-level reference model and one output compare process.
module tb_sdcard_cmd_seq;

    localparam int NCR_MAX   = 8;
    localparam int TOKEN_MAX = 4095;
    localparam int BLOCK_LEN = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  clk_div;
    logic        cmd_start;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic [2:0]  rsp_extra;
    logic        data_rd;
    logic        busy, done;
    logic [7:0]  r1;
    logic [31:0] rsp_ext;
    logic        err_timeout, err_token, err_crc;
    logic        dat_valid;
    logic [7:0]  dat_byte;
    logic [3:0]  m_adr;
    logic        m_cs, m_we;
    logic [3:0]  m_sel;
    logic [31:0] m_d, m_q;

    sdcard_cmd_seq dut (
        .clk(clk), .reset(reset), .clk_div(clk_div),
        .cmd_start(cmd_start), .cmd_index(cmd_index),
        .cmd_arg(cmd_arg), .rsp_extra(rsp_extra), .data_rd(data_rd),
        .busy(busy), .done(done), .r1(r1), .rsp_ext(rsp_ext),
        .err_timeout(err_timeout), .err_token(err_token),
        .err_crc(err_crc), .dat_valid(dat_valid), .dat_byte(dat_byte),
        .m_adr(m_adr), .m_cs(m_cs), .m_we(m_we), .m_sel(m_sel),
        .m_d(m_d), .m_q(m_q)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endfunction

    function automatic logic [6:0] crc7_upd(logic [6:0] c, logic [7:0] b);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[6] ^ b[i];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction

    function automatic logic [15:0] crc16_upd(logic [15:0] c, logic [7:0] b);
        logic fb;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ b[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Engine + card model state
    logic        eng_busy, eng_sel;
    int          eng_cnt;
    logic [7:0]  eng_rx, eng_pend;
    logic [6:0]  eng_crc7;
    logic [15:0] eng_crc16;
    logic [7:0]  card_q[$];
    logic [8:0]  mosi_q[$];
    logic [7:0]  exp_div;

    always_comb begin
        m_q = 32'd0;
        if (m_adr == 4'd0) begin
            m_q[8]   = eng_busy;
            m_q[7:0] = eng_rx;
        end else if (m_adr == 4'd1) begin
            m_q[31:24] = {eng_crc7, 1'b1};
            m_q[15:0]  = eng_crc16;
        end
    end

    // Byte engine: random latency per byte, CRC7 on MOSI, CRC16 on MISO.
    always @(posedge clk) begin
        if (reset) begin
            eng_busy  <= 1'b0;
            eng_sel   <= 1'b0;
            eng_cnt   <= 0;
            eng_rx    <= 8'hFF;
            eng_crc7  <= 7'd0;
            eng_crc16 <= 16'd0;
        end else begin
            if (eng_busy) begin
                if (eng_cnt <= 1) begin
                    eng_busy  <= 1'b0;
                    eng_rx    <= eng_pend;
                    eng_crc16 <= crc16_upd(eng_crc16, eng_pend);
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end
            if (m_cs && m_we && m_adr == 4'd0) begin
                eng_sel <= m_d[12];
                if (m_d[8]) begin
                    chk("write_while_busy", {31'd0, eng_busy}, 32'd0);
                    chk("write_div", {24'd0, m_d[31:24]}, {24'd0, exp_div});
                    chk("write_sel", {28'd0, m_sel}, 32'hB);
                    chk("write_ctl", {29'd0, m_d[19:18], m_d[9]}, 32'd0);
                    mosi_q.push_back({m_d[12], m_d[7:0]});
                    eng_crc7 <= crc7_upd(eng_sel ? eng_crc7 : 7'd0, m_d[7:0]);
                    if (card_q.size() != 0) eng_pend <= card_q.pop_front();
                    else eng_pend <= 8'hFF;
                    eng_busy <= 1'b1;
                    eng_cnt  <= $urandom_range(1, 4);
                end
            end
            if (m_cs && m_we && m_adr == 4'd1 && m_sel == 4'b0011)
                eng_crc16 <= m_d[15:0];
        end
    end

    // Reference model: expected outcome of one command from card bytes.
    logic [7:0]  resp[$];
    logic [7:0]  exp_r1;
    logic [31:0] exp_ext;
    logic        exp_to, exp_tok, exp_crc;
    logic [7:0]  exp_data[$];
    logic [8:0]  exp_mosi[$];

    function automatic logic [7:0] rb(int i);
        return (i < resp.size()) ? resp[i] : 8'hFF;
    endfunction

    task automatic model(input logic [5:0] idx, input logic [31:0] arg,
                         input int ext, input logic rd);
        int p;
        int t;
        logic [6:0]  c;
        logic [7:0]  cmd[5];
        logic [7:0]  b;
        logic [15:0] dc;
        p = 0;
        c = 7'd0;
        b = 8'hFF;
        cmd[0] = {2'b01, idx};
        cmd[1] = arg[31:24];
        cmd[2] = arg[23:16];
        cmd[3] = arg[15:8];
        cmd[4] = arg[7:0];
        exp_mosi.delete();
        exp_data.delete();
        exp_mosi.push_back({1'b0, 8'hFF});
        for (int k = 0; k < 5; k++) begin
            c = crc7_upd(c, cmd[k]);
            exp_mosi.push_back({1'b1, cmd[k]});
        end
        exp_mosi.push_back({1'b1, c, 1'b1});
        exp_r1 = 8'hFF; exp_ext = 32'd0;
        exp_to = 1'b0; exp_tok = 1'b0; exp_crc = 1'b0;
        for (int i = 0; i < NCR_MAX; i++) begin
            b = rb(p); p++;
            if (!b[7]) begin exp_r1 = b; break; end
        end
        if (exp_r1 == 8'hFF) exp_to = 1'b1;
        if (!exp_to) begin
            for (int k = 0; k < ext; k++) begin
                exp_ext = {exp_ext[23:0], rb(p)}; p++;
            end
            if (rd && exp_r1 == 8'h00) begin
                for (t = 0; t < TOKEN_MAX; t++) begin
                    b = rb(p); p++;
                    if (b == 8'hFE || b[7:4] == 4'h0) break;
                end
                if (t == TOKEN_MAX) exp_to = 1'b1;
                else if (b != 8'hFE) exp_tok = 1'b1;
                else begin
                    dc = 16'd0;
                    for (int i = 0; i < BLOCK_LEN + 2; i++) begin
                        b = rb(p); p++;
                        if (i < BLOCK_LEN) exp_data.push_back(b);
                        dc = crc16_upd(dc, b);
                    end
                    exp_crc = (dc != 16'd0);
                end
            end
        end
        repeat (p + 1) exp_mosi.push_back({1'b1, 8'hFF});
    endtask

    task automatic build_read(input int ncr, input logic [7:0] r1b,
                              input int ext, input int tokd,
                              input logic [7:0] tok, input bit rnd,
                              input int flip);
        logic [15:0] c;
        logic [7:0]  b;
        c = 16'd0;
        resp.delete();
        repeat (ncr) resp.push_back(8'hFF);
        resp.push_back(r1b);
        repeat (ext) resp.push_back(8'($urandom));
        repeat (tokd) resp.push_back(8'hFF);
        resp.push_back(tok);
        for (int i = 0; i < BLOCK_LEN; i++) begin
            b = rnd ? 8'($urandom) : 8'(i);
            resp.push_back(b);
            c = crc16_upd(c, b);
        end
        if (flip >= 0) c = c ^ (16'd1 << flip);
        resp.push_back(c[15:8]);
        resp.push_back(c[7:0]);
    endtask

    // Compare process: data strobes and completion outputs.
    int done_cnt = 0;
    int dv_cnt = 0;
    logic [7:0] e_byte;

    always @(negedge clk) begin
        if (!reset) begin
            if (dat_valid) begin
                dv_cnt++;
                n_chk++;
                if (exp_data.size() == 0) begin
                    $display("FAIL dat_extra: got byte %h, required none",
                             dat_byte);
                end else begin
                    e_byte = exp_data.pop_front();
                    if (dat_byte === e_byte) n_pass++;
                    else $display("FAIL dat_byte: got %h, required %h",
                                  dat_byte, e_byte);
                end
            end
            if (done) begin
                done_cnt++;
                chk("r1", {24'd0, r1}, {24'd0, exp_r1});
                chk("rsp_ext", rsp_ext, exp_ext);
                chk("err_timeout", {31'd0, err_timeout}, {31'd0, exp_to});
                chk("err_token", {31'd0, err_token}, {31'd0, exp_tok});
                chk("err_crc", {31'd0, err_crc}, {31'd0, exp_crc});
                chk("dat_missing", exp_data.size(), 0);
                chk("mosi_len", mosi_q.size(), exp_mosi.size());
                for (int i = 0; i < mosi_q.size() && i < exp_mosi.size(); i++)
                    chk($sformatf("mosi[%0d]", i), {23'd0, mosi_q[i]},
                        {23'd0, exp_mosi[i]});
                chk("desel", {31'd0, eng_sel}, 32'd0);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    int d0;

    task automatic start_cmd(input logic [5:0] idx, input logic [31:0] arg,
                             input int ext, input logic rd,
                             input logic [7:0] div);
        model(idx, arg, ext, rd);
        exp_div = div;
        card_q.delete();
        repeat (7) card_q.push_back(8'hFF);
        foreach (resp[i]) card_q.push_back(resp[i]);
        mosi_q.delete();
        dv_cnt = 0;
        @(posedge clk); #1;
        cmd_index = idx; cmd_arg = arg; rsp_extra = 3'(ext);
        data_rd = rd; clk_div = div; cmd_start = 1'b1;
        d0 = done_cnt;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        cmd_index = 6'($urandom); cmd_arg = $urandom;
        rsp_extra = 3'($urandom); data_rd = 1'($urandom);
        clk_div = 8'($urandom);
        chk("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done();
        bit got;
        got = 1'b0;
        for (int c = 0; c < 12000; c++) begin
            @(posedge clk);
            if (done_cnt != d0) begin got = 1'b1; break; end
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("done_single", done_cnt - d0, 32'd1);
        chk("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    logic [7:0]  s9[9];
    logic [15:0] c16;
    int          ncr, ext, tokd, flip;
    logic        rd;
    logic [7:0]  r1b, tok;

    initial begin
        reset = 1'b1; cmd_start = 1'b0; cmd_index = 6'd0; cmd_arg = 32'd0;
        rsp_extra = 3'd0; data_rd = 1'b0; clk_div = 8'd0;
        s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        c16 = 16'd0;
        foreach (s9[i]) c16 = crc16_upd(c16, s9[i]);
        chk("crc16_model_pin", {16'd0, c16}, 32'h31C3);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_r1", {24'd0, r1}, 32'hFF);
        chk("rst_rsp_ext", rsp_ext, 32'd0);
        chk("rst_err", {29'd0, err_timeout, err_token, err_crc}, 32'd0);
        chk("rst_dat_valid", {31'd0, dat_valid}, 32'd0);
        chk("rst_bus", {30'd0, m_cs, m_we}, 32'd0);
        reset = 1'b0;

        resp = '{8'hFF, 8'hFF, 8'h01};
        start_cmd(6'd0, 32'd0, 0, 1'b0, 8'h00);
        wait_done();
        chk("cmd0_crc_byte", {23'd0, mosi_q[6]}, 32'h195);
        chk("cmd0_r1_pin", {24'd0, r1}, 32'h01);

        resp = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hAA};
        start_cmd(6'd8, 32'h000001AA, 4, 1'b0, 8'h03);
        wait_done();
        chk("cmd8_crc_byte", {23'd0, mosi_q[6]}, 32'h187);
        chk("cmd8_rsp_pin", rsp_ext, 32'h000001AA);

        resp.delete();
        start_cmd(6'd55, 32'h12345678, 2, 1'b1, 8'h10);
        wait_done();
        chk("ncr_to_xfers", mosi_q.size(), 32'd16);
        chk("ncr_to_pin", {23'd0, err_timeout, r1}, 32'h1FF);

        build_read(0, 8'h00, 0, 3, 8'hFE, 1'b0, -1);
        start_cmd(6'd17, 32'h00000200, 0, 1'b1, 8'h01);
        wait_done();
        chk("rd_dv_count", dv_cnt, 32'd512);
        chk("rd_crc_pin", {31'd0, err_crc}, 32'd0);

        build_read(0, 8'h00, 0, 3, 8'hFE, 1'b0, 5);
        start_cmd(6'd17, 32'h00000200, 0, 1'b1, 8'h01);
        wait_done();
        chk("rd_badcrc_pin", {31'd0, err_crc}, 32'd1);

        build_read(0, 8'h00, 0, 3, 8'h05, 1'b0, -1);
        start_cmd(6'd17, 32'h00000400, 0, 1'b1, 8'h01);
        wait_done();
        chk("tok_err_pin", {31'd0, err_token}, 32'd1);
        chk("tok_no_data", dv_cnt, 32'd0);

        resp = '{8'hFF, 8'h01};
        start_cmd(6'd0, 32'd0, 0, 1'b0, 8'h02);
        repeat (30) @(posedge clk);
        #1 cmd_start = 1'b1;
        @(posedge clk);
        #1 cmd_start = 1'b0;
        wait_done();

        build_read(1, 8'h00, 0, 2, 8'hFE, 1'b1, -1);
        start_cmd(6'd17, 32'h00000600, 0, 1'b1, 8'h02);
        for (int c = 0; c < 12000; c++) begin
            @(posedge clk);
            if (dv_cnt >= 100) break;
        end
        chk("abort_at_byte", dv_cnt, 32'd100);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_cs", {30'd0, m_cs, m_we}, 32'd0);
        chk("abort_busy", {30'd0, busy, done}, 32'd0);
        chk("abort_dv", {31'd0, dat_valid}, 32'd0);
        reset = 1'b0;
        card_q.delete();
        exp_data.delete();
        resp = '{8'hFF, 8'hFF, 8'h01};
        start_cmd(6'd0, 32'd0, 0, 1'b0, 8'h00);
        wait_done();

        for (int it = 0; it < 6; it++) begin
            ncr  = $urandom_range(0, 9);
            ext  = $urandom_range(0, 4);
            rd   = 1'($urandom_range(0, 1));
            r1b  = (rd && $urandom_range(0, 3) != 0) ? 8'h00
                                                     : {1'b0, 7'($urandom)};
            tokd = $urandom_range(0, 5);
            tok  = ($urandom_range(0, 4) == 0) ? {4'h0, 4'($urandom)} : 8'hFE;
            flip = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : -1;
            build_read(ncr, r1b, ext, tokd, tok, 1'b1, flip);
            start_cmd(6'($urandom), $urandom, ext, rd, 8'($urandom));
            wait_done();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sdcard_cmd_seq.md
Name: sdcard_cmd_seq

Overview:
- Hardware command sequencer for the SPI-mode SD card byte engine; acts as the engine's only bus master on its MMIO register port.
- Issues one complete SD command frame and collects the R1 response plus 0–4 extra bytes (R3/R7).
- Optionally receives one data block, streamed byte-by-byte to the host, and checks its CRC16.
- Frees firmware from per-byte polling.

Parameters:
NCR_MAX, 8, max 0xFF bytes polled before R1; exceeded -> timeout
TOKEN_MAX, 4095, max 0xFF bytes polled for start token; exceeded -> timeout
BLOCK_LEN, 512, data bytes per block

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
clk_div  in  8  SCK divider value written to the engine with every byte
cmd_start  in  1  start pulse; sampled only in IDLE
cmd_index  in  6  command index
cmd_arg  in  32  argument, bit 0 = MSB
rsp_extra  in  3  extra response bytes after R1, 0..4
data_rd  in  1  expect one read data block
busy  out  1  high from accepted start to done
done  out  1  one-cycle completion pulse
r1  out  8  R1 byte, 0xFF on timeout
rsp_ext  out  32  extra bytes, first received in bits 0:7
err_timeout, err_token, err_crc  out  1 each  status, valid at done; cleared on next start
dat_valid  out  1  one-cycle strobe per data byte
dat_byte  out  8  data byte
m_adr  out  4  engine register address
m_cs, m_we  out  1 each  engine bus strobes
m_sel  out  4  byte lanes
m_d  out  32  write data
m_q  in  32  read data, combinational, same cycle

Behaviour:
- Reset: busy=0, done=0, r1=FF, rsp_ext=0, all err=0, dat_valid=0, m_cs=0, m_we=0, FSM=IDLE.
- Reset mid-operation aborts immediately; the engine shares the reset and deselects.
- Engine register map:
  - adr 0, write: d[0:7] divider, d[19] select, d[22] wait, d[23] go, d[24:31] tx byte.
  - adr 0, read: q[23] busy, q[24:31] rx byte.
  - adr 1, read: q[0:7] CRC7 byte with stop bit. adr 1, write with sel=0011: d[16:31] presets CRC16.
  - adr 1, read: q[16:31] CRC16.
  - CRC7 restarts on a byte write issued while deselected.
- Byte transfer (XFER):
  - one write cycle: m_cs=1, m_we=1, adr=0, sel=1011, d[0:7]=clk_div, d[12:13]=0, d[19]=sel_bit, d[22]=0, d[23]=1, d[24:31]=tx.
  - then POLL: m_cs=1, m_we=0, adr=0 every cycle until q[23]=0; latch q[24:31] as rx in that cycle.
  - never write while the engine is busy.
- Sequence, one XFER per step:
  - PRE: tx FF, sel_bit=0.
  - CMD0..4: 0x40|cmd_index, then arg bytes MSB first, sel_bit=1.
  - CRC: read adr 1 for one cycle, tx q[0:7].
  - NCR: tx FF, up to NCR_MAX XFERs; first rx with bit 0 = 0 -> r1. Exhausted -> err_timeout, go TAIL.
  - EXT: rsp_extra XFERs of FF, shifted into rsp_ext.
  - If data_rd=0 or r1≠00 -> TAIL.
  - TOK: FF XFERs up to TOKEN_MAX.
    - rx FE -> write adr 1 sel=0011 d[16:31]=0, go DATA.
    - rx with bits 0:3 = 0 -> err_token, TAIL.
    - exhausted -> err_timeout, TAIL.
  - DATA: BLOCK_LEN XFERs of FF; each rx -> dat_byte, dat_valid pulse the cycle after the latch.
  - DCRC: 2 XFERs of FF; then read adr 1; q[16:31]≠0 -> err_crc.
  - TAIL: XFER of FF with sel_bit=1.
  - DESEL: one write adr 0, sel=0010, d[19]=0, d[23]=0.
  - DONE: done=1 for one cycle, busy=0, go IDLE.
- cmd_start while busy is ignored. Inputs are latched at start; later changes are ignored.
- Byte counter is 12 bits, compared against BLOCK_LEN-1 with no wrap.
- Timeouts count bytes, not cycles.

Test Plan:
- CMD0, arg 0, clk_div=0; card model returns FF,FF,01 -> MOSI bytes FF,40,00,00,00,00,95; r1=01, no errors, single done pulse.
- CMD8, arg 0x000001AA, rsp_extra=4; card returns 01,00,00,01,AA -> CRC byte 87, rsp_ext=000001AA.
- Card holds MISO high after command -> exactly 8 NCR polls, r1=FF, err_timeout=1, TAIL and DESEL still executed.
- CMD17, data_rd=1; card returns 00, 3×FF, FE, 512 bytes i&0xFF, correct CRC16 -> 512 dat_valid pulses in order, err_crc=0.
- Same read with one CRC bit flipped -> err_crc=1. Token 05 instead of FE -> err_token=1, no dat_valid.
- Assert reset at data byte 100 -> m_cs=0 next cycle, busy=0, FSM idle. A new CMD0 then completes normally. cmd_start pulsed while busy has no effect.
